// File: rtl/mips_reg_file_if.sv
// -----------------------------------------------------------------------------
// mips_reg_file_if
// Bundle that ties the decode/writeback side of the datapath to the MIPS
// general-purpose register file.
//
//   w_en  1   write enable, sampled on the rising clock edge
//   a1    5   read address, port 1 (rs)
//   a2    5   read address, port 2 (rt)
//   a3    5   write address (rd/rt)
//   wd3   32  write data
//   rd1   32  read data, port 1 = reg[a1]
//   rd2   32  read data, port 2 = reg[a2]
//
// Modports:
//   master - the datapath: drives addresses, enable and write data, sees reads
//   slave  - the register file: receives addresses and write data, drives reads
// -----------------------------------------------------------------------------
interface mips_reg_file_if;
  logic        w_en;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  modport master (
    output w_en, a1, a2, a3, wd3,
    input  rd1, rd2
  );

  modport slave (
    input  w_en, a1, a2, a3, wd3,
    output rd1, rd2
  );
endinterface : mips_reg_file_if

// File: rtl/mips_reg_file.sv
// -----------------------------------------------------------------------------
// mips_reg_file
// 32 x 32-bit general-purpose register file for the MIPS datapath: two
// combinational read ports and one synchronous write port. Register 0 is
// hardwired to zero: writes to it are discarded and reads return 0.
//
// Ports:
//   clk  1  clock; every state change happens on its rising edge except reset
//   rst  1  asynchronous active-high reset; clears all registers immediately
//   bus     mips_reg_file_if.slave (w_en, a1, a2, a3, wd3 in; rd1, rd2 out)
//
// There is no write-to-read bypass: a read of the register being written
// returns the old contents until the edge and the new contents after it.
// -----------------------------------------------------------------------------
module mips_reg_file (
  input  logic                  clk,
  input  logic                  rst,
  mips_reg_file_if.slave        bus
);

  logic [31:0] regs [0:31];

  // NOTE: the storage carries an asynchronous reset on every word, so it maps
  // to flip-flops rather than a RAM macro; that is what makes "cleared the
  // moment rst rises, no clock needed" possible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.w_en && (bus.a3 != 5'd0)) begin
      // NOTE: non-blocking assignment, so reads in the same time step still
      // see the pre-edge value.
      // An unknown w_en makes this condition non-true in simulation, so the
      // write is dropped rather than corrupting state.
      regs[bus.a3] <= bus.wd3;
    end
  end

  // Register 0 is never written, but the read mux still forces zero so the
  // hardwired behaviour does not depend on the storage contents.
  // NOTE: both branches assign, so this is pure combinational logic with no
  // inferred latch.
  always_comb begin
    bus.rd1 = (bus.a1 == 5'd0) ? 32'h0000_0000 : regs[bus.a1];
    bus.rd2 = (bus.a2 == 5'd0) ? 32'h0000_0000 : regs[bus.a2];
  end

endmodule : mips_reg_file

// File: tb/tb_mips_reg_file.sv
// -----------------------------------------------------------------------------
// tb_mips_reg_file
// Directed self-checking bench for mips_reg_file. Inputs change 1 ns after
// a rising edge; outputs are sampled there as well, away from the edge.
// -----------------------------------------------------------------------------
module tb_mips_reg_file;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mips_reg_file_if bus ();

  mips_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    bus.w_en = 1'b0;
    bus.a1   = 5'd0;
    bus.a2   = 5'd0;
    bus.a3   = 5'd0;
    bus.wd3  = 32'h0;

    // Reset asserted between edges clears everything without a clock.
    #2 rst = 1'b1;
    #1;
    bus.a1 = 5'd3;
    bus.a2 = 5'd25;
    #1;
    check("reset_rd1_a3", bus.rd1, 32'h0);
    check("reset_rd2_a25", bus.rd2, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Outputs hold zero over several edges with w_en low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_rd1", bus.rd1, 32'h0);
      check("post_reset_rd2", bus.rd2, 32'h0);
    end

    // Two writes, then read both back on separate ports.
    bus.w_en = 1'b1;
    bus.a3   = 5'd3;
    bus.wd3  = 32'hDEAD_BEEF;
    tick();
    bus.a3   = 5'd25;
    bus.wd3  = 32'h0000_0019;
    tick();
    bus.w_en = 1'b0;
    bus.a1   = 5'd3;
    bus.a2   = 5'd25;
    #1;
    check("write_rd1_r3", bus.rd1, 32'hDEAD_BEEF);
    check("write_rd2_r25", bus.rd2, 32'h0000_0019);
    bus.a2 = 5'd3;
    #1;
    check("same_addr_rd1", bus.rd1, 32'hDEAD_BEEF);
    check("same_addr_rd2", bus.rd2, 32'hDEAD_BEEF);

    // Writes to register 0 are discarded.
    bus.w_en = 1'b1;
    bus.a3   = 5'd0;
    bus.wd3  = 32'hFFFF_FFFF;
    tick();
    bus.w_en = 1'b0;
    bus.a1   = 5'd0;
    bus.a2   = 5'd0;
    #1;
    check("r0_rd1", bus.rd1, 32'h0);
    check("r0_rd2", bus.rd2, 32'h0);

    // w_en low: nothing changes over two edges.
    bus.w_en = 1'b0;
    bus.a3   = 5'd3;
    bus.wd3  = 32'h1234_5678;
    tick();
    tick();
    bus.a1 = 5'd3;
    #1;
    check("wen_low_r3", bus.rd1, 32'hDEAD_BEEF);

    // Read-during-write: old value before the edge, new value after.
    bus.w_en = 1'b1;
    bus.a3   = 5'd7;
    bus.wd3  = 32'h1111_1111;
    tick();
    bus.a1   = 5'd7;
    bus.wd3  = 32'h2222_2222;
    #1;
    check("rdw_before_edge", bus.rd1, 32'h1111_1111);
    tick();
    check("rdw_after_edge", bus.rd1, 32'h2222_2222);

    // Back-to-back writes to one address: last one wins; neighbour untouched.
    bus.a3  = 5'd9;
    bus.wd3 = 32'hAAAA_0001;
    tick();
    bus.wd3 = 32'hAAAA_0002;
    tick();
    bus.w_en = 1'b0;
    bus.a1   = 5'd9;
    bus.a2   = 5'd8;
    #1;
    check("b2b_last_wins", bus.rd1, 32'hAAAA_0002);
    check("neighbour_r8", bus.rd2, 32'h0);
    bus.a1 = 5'd25;
    bus.a2 = 5'd7;
    #1;
    check("r25_retained", bus.rd1, 32'h0000_0019);
    check("r7_retained", bus.rd2, 32'h2222_2222);

    // Async reset mid-write: raised between edges, outputs clear at once.
    bus.a1   = 5'd3;
    bus.a2   = 5'd25;
    bus.w_en = 1'b1;
    bus.a3   = 5'd5;
    bus.wd3  = 32'h5555_5555;
    #2 rst = 1'b1;
    #1;
    check("async_rst_rd1", bus.rd1, 32'h0);
    check("async_rst_rd2", bus.rd2, 32'h0);
    tick();
    tick();
    bus.w_en = 1'b0;
    rst      = 1'b0;
    #1;
    for (int i = 1; i < 32; i++) begin
      bus.a1 = 5'(i);
      bus.a2 = 5'(i);
      #1;
      check($sformatf("cleared_rd1_r%0d", i), bus.rd1, 32'h0);
      check($sformatf("cleared_rd2_r%0d", i), bus.rd2, 32'h0);
    end

    // First edge after release accepts a write.
    bus.w_en = 1'b1;
    bus.a3   = 5'd5;
    bus.wd3  = 32'h5A5A_A5A5;
    tick();
    bus.w_en = 1'b0;
    bus.a1   = 5'd5;
    #1;
    check("first_write_after_rst", bus.rd1, 32'h5A5A_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mips_reg_file
